// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the UART command path: sync byte, opcodes, error codes
// and the parser state encoding.
package mem_ctrl_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_BOOT  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ERR_OPC = 2'd0,
    ERR_SEL = 2'd1,
    ERR_CHK = 2'd2,
    ERR_TMO = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_SEL,
    ST_ADDR,
    ST_DHI,
    ST_DLO,
    ST_CHK,
    ST_HOLD
  } state_e;

  function automatic logic op_legal(input logic [7:0] b);
    return (b >= 8'd1) && (b <= 8'd3);
  endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap counter. Cleared while disabled or on restart; expired is
// high on the TIMEOUT_CYCLES-th consecutive enabled cycle without a restart.
module byte_gap_timer #(
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || restart) cnt_d = '0;
    else if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses framed UART commands (sync, op, sel, addr, [data], xor checksum) and
// holds the decoded command until the downstream controller accepts it.
module uart_cmd_parser
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_SELECT_BITS = 4,
  parameter int TIMEOUT_CYCLES  = 12000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [1:0]                 cmd_op,
  output logic [MEM_SELECT_BITS-1:0] cmd_sel,
  output logic [7:0]                 cmd_addr,
  output logic [15:0]                cmd_data,
  output logic                       err_valid,
  output logic [1:0]                 err_code,
  output logic [7:0]                 drop_count
);

  state_e                     state_q, state_d;
  op_e                        op_q, op_d;
  logic [MEM_SELECT_BITS-1:0] sel_q, sel_d;
  logic [7:0]                 addr_q, addr_d;
  logic [15:0]                data_q, data_d;
  logic [7:0]                 csum_q, csum_d;
  logic [7:0]                 drop_q, drop_d;
  logic                       err_q, err_d;
  logic [1:0]                 ecode_q, ecode_d;
  logic                       gap_en, gap_expired;

  assign gap_en = (state_q != ST_IDLE) && (state_q != ST_HOLD);

  byte_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap (
    .clk     (clk),
    .reset   (reset),
    .enable  (gap_en),
    .restart (rx_valid),
    .expired (gap_expired)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    csum_d  = csum_q;
    drop_d  = drop_q;
    err_d   = 1'b0;
    ecode_d = ecode_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_OPC;
          csum_d  = SYNC_BYTE;
          data_d  = '0;
        end
      end
      ST_HOLD: begin
        // a byte on the handshake cycle is still a dropped byte
        if (rx_valid && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        if (cmd_ready) state_d = ST_IDLE;
      end
      default: begin
        // rx_valid is checked first so a byte on the expiry cycle wins
        if (rx_valid) begin
          csum_d = csum_q ^ rx_data;
          case (state_q)
            ST_OPC: begin
              if (op_legal(rx_data)) begin
                op_d    = op_e'(rx_data[1:0]);
                state_d = ST_SEL;
              end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                ecode_d = ERR_OPC;
              end
            end
            ST_SEL: begin
              if ((rx_data >> MEM_SELECT_BITS) == 8'd0) begin
                sel_d   = rx_data[MEM_SELECT_BITS-1:0];
                state_d = ST_ADDR;
              end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                ecode_d = ERR_SEL;
              end
            end
            ST_ADDR: begin
              addr_d  = rx_data;
              state_d = (op_q == OP_WRITE) ? ST_DHI : ST_CHK;
            end
            ST_DHI: begin
              data_d[15:8] = rx_data;
              state_d      = ST_DLO;
            end
            ST_DLO: begin
              data_d[7:0] = rx_data;
              state_d     = ST_CHK;
            end
            ST_CHK: begin
              if (rx_data == csum_q) begin
                state_d = ST_HOLD;
              end else begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                ecode_d = ERR_CHK;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end else if (gap_expired) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          ecode_d = ERR_TMO;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      csum_q  <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
      ecode_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      csum_q  <= csum_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      ecode_q <= ecode_d;
    end
  end

  assign cmd_valid  = (state_q == ST_HOLD);
  assign cmd_op     = op_q;
  assign cmd_sel    = sel_q;
  assign cmd_addr   = addr_q;
  assign cmd_data   = data_q;
  assign err_valid  = err_q;
  assign err_code   = ecode_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a short timeout so gap tests stay fast.
module tb_uart_cmd_parser;

  localparam int MSB = 4;
  localparam int T   = 20;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           rx_valid = 1'b0;
  logic [7:0]     rx_data = 8'h00;
  logic           cmd_ready = 1'b0;
  logic           cmd_valid;
  logic [1:0]     cmd_op;
  logic [MSB-1:0] cmd_sel;
  logic [7:0]     cmd_addr;
  logic [15:0]    cmd_data;
  logic           err_valid;
  logic [1:0]     err_code;
  logic [7:0]     drop_count;

  int total = 0, bad = 0, err_cnt = 0, hs_cnt = 0;

  uart_cmd_parser #(.MEM_SELECT_BITS(MSB), .TIMEOUT_CYCLES(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_sel    (cmd_sel),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .err_valid  (err_valid),
    .err_code   (err_code),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err_valid) err_cnt <= err_cnt + 1;
    if (cmd_valid && cmd_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // called at a negedge; byte is sampled at the next posedge
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, h0, k;

    // reset state
    #2;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_fields", {cmd_op, cmd_sel, cmd_addr, cmd_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // WRITE frame held by cmd_ready=0, then drops and handshake
    e0 = err_cnt;
    cmd_ready = 1'b0;
    send_bytes('{8'hA5, 8'h02, 8'h03, 8'h10, 8'h12, 8'h34, 8'h92});
    chk("wr_valid", cmd_valid, 1);
    chk("wr_op", cmd_op, 2);
    chk("wr_sel", cmd_sel, 3);
    chk("wr_addr", cmd_addr, 8'h10);
    chk("wr_data", cmd_data, 16'h1234);
    send_bytes('{8'h11, 8'h22, 8'h33});
    chk("hold_drop3", drop_count, 3);
    chk("hold_valid", cmd_valid, 1);
    chk("hold_stable", {cmd_op, cmd_sel, cmd_addr, cmd_data}, {2'd2, 4'd3, 8'h10, 16'h1234});
    h0 = hs_cnt;
    cmd_ready = 1'b1;
    send(8'h44);
    chk("hs_valid_low", cmd_valid, 0);
    chk("hs_cycle_drop", drop_count, 4);
    idle(2);
    chk("hs_once", hs_cnt - h0, 1);
    chk("wr_no_err", err_cnt - e0, 0);

    // READ frame preceded by junk
    e0 = err_cnt; h0 = hs_cnt;
    send_bytes('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h05, 8'h20, 8'h81});
    chk("rd_valid", cmd_valid, 1);
    chk("rd_fields", {cmd_op, cmd_sel, cmd_addr, cmd_data}, {2'd1, 4'd5, 8'h20, 16'h0000});
    idle(1);
    chk("rd_valid_low", cmd_valid, 0);
    chk("rd_hs", hs_cnt - h0, 1);
    chk("rd_no_err", err_cnt - e0, 0);

    // checksum error
    send_bytes('{8'hA5, 8'h01, 8'h05, 8'h20, 8'h80});
    chk("csum_err_valid", err_valid, 1);
    chk("csum_err_code", err_code, 2);
    chk("csum_no_cmd", cmd_valid, 0);
    idle(1);
    chk("csum_pulse_1cyc", err_valid, 0);
    chk("csum_code_held", err_code, 2);

    // bad opcode; the offending 0xA5 must not restart a frame
    h0 = hs_cnt;
    send_bytes('{8'hA5, 8'hA5});
    chk("opc_err_valid", err_valid, 1);
    chk("opc_err_code", err_code, 0);
    send_bytes('{8'h01, 8'h05, 8'h20, 8'h81});
    idle(1);
    chk("opc_no_resync", cmd_valid, 0);
    chk("opc_no_hs", hs_cnt - h0, 0);

    // select boundary
    send_bytes('{8'hA5, 8'h01, 8'h10});
    chk("sel_err_valid", err_valid, 1);
    chk("sel_err_code", err_code, 1);
    send_bytes('{8'hA5, 8'h01, 8'h0F, 8'hFF, 8'h54});
    chk("sel_max_ok", {cmd_valid, cmd_sel}, {1'b1, 4'hF});
    idle(1);

    // timeout after A5 01, then a BOOT frame
    send_bytes('{8'hA5, 8'h01});
    for (k = 1; k <= T + 5; k++) begin
      @(negedge clk);
      if (err_valid) break;
    end
    chk("tmo_cycles", k, T);
    chk("tmo_code", err_code, 3);
    send_bytes('{8'hA5, 8'h03, 8'h00, 8'h07, 8'hA1});
    chk("boot_valid", cmd_valid, 1);
    chk("boot_fields", {cmd_op, cmd_sel, cmd_addr, cmd_data}, {2'd3, 4'd0, 8'h07, 16'h0000});
    idle(1);

    // byte on the expiry cycle wins
    e0 = err_cnt;
    send_bytes('{8'hA5, 8'h01});
    idle(T - 1);
    send_bytes('{8'h05, 8'h20, 8'h81});
    chk("edge_byte_wins", cmd_valid, 1);
    chk("edge_no_err", err_cnt - e0, 0);
    idle(1);

    // drop_count saturation, then reset in HOLD
    cmd_ready = 1'b0;
    send_bytes('{8'hA5, 8'h01, 8'h05, 8'h20, 8'h81});
    for (int i = 0; i < 260; i++) send(8'(i));
    chk("drop_sat", drop_count, 255);
    chk("sat_valid", cmd_valid, 1);
    e0 = err_cnt;
    reset = 1'b1;
    #1;
    chk("rst_hold_valid", cmd_valid, 0);
    chk("rst_hold_drop", drop_count, 0);
    chk("rst_hold_addr", cmd_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_hold_no_err", err_cnt - e0, 0);

    // reset mid-frame: tail bytes must be ignored in IDLE
    cmd_ready = 1'b1;
    send_bytes('{8'hA5, 8'h02, 8'h03});
    e0 = err_cnt;
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs", {err_valid, cmd_valid}, 0);
    @(negedge clk);
    reset = 1'b0;
    h0 = hs_cnt;
    send_bytes('{8'h10, 8'h12, 8'h34, 8'h92});
    idle(2);
    chk("rst_mid_idle", cmd_valid, 0);
    chk("rst_mid_no_hs", hs_cnt - h0, 0);
    chk("rst_mid_no_err", err_cnt - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
